// File: rtl/bench_report_tx_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bench_report_tx_if : valid/ready byte stream toward the UART sender    |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
interface bench_report_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/bench_report_tx.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bench_report_tx : snapshots benchmark results on done rise and streams |
// | them as a 29-byte checksummed frame.                  Rev 1.0          |
// +-----------------------------------------------------------------------+
module bench_report_tx #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  wire         clk,
  input  wire         rst,
  input  wire         done,
  input  wire  [31:0] t_cond0,
  input  wire  [31:0] t_cond1,
  input  wire  [31:0] t_cond2,
  input  wire  [31:0] t_cond3,
  input  wire  [31:0] t_total,
  input  wire  [31:0] t_runtime,
  input  wire  [15:0] ops_per_condition,
  input  wire  [1:0]  winner_code,
  input  wire         resend,
  bench_report_tx_if.master tx,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_END  = 2'd2;

  localparam logic [4:0] c_LAST_IDX = 5'd28;

  logic [1:0]       r_state;
  logic             r_done_d;
  logic             r_snap_valid;
  logic             r_overrun;
  logic [4:0]       r_idx;
  logic [7:0]       r_csum;
  // Frame byte k (1..27) lives in r_snap[27-k], so the MSB byte is byte 1.
  logic [26:0][7:0] r_snap;

  logic             w_rise;
  logic             w_send;
  logic [7:0]       w_byte;

  assign w_rise = done & ~r_done_d;
  assign w_send = (r_state == S_SEND);

  always_comb begin
    w_byte = 8'h00;
    if (r_idx == 5'd0)
      w_byte = SYNC_BYTE;
    else if (r_idx == c_LAST_IDX)
      w_byte = r_csum;
    else
      w_byte = r_snap[5'd27 - r_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_done_d     <= 1'b0;
      r_snap_valid <= 1'b0;
      r_overrun    <= 1'b0;
      r_idx        <= 5'd0;
      r_csum       <= 8'h00;
      r_snap       <= '0;
    end else begin
      r_done_d <= done;
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_snap       <= {6'b0, winner_code, ops_per_condition,
                             t_cond0, t_cond1, t_cond2, t_cond3,
                             t_total, t_runtime};
            r_snap_valid <= 1'b1;
            r_state      <= S_SEND;
            r_idx        <= 5'd0;
            r_csum       <= 8'h00;
          end else if (resend && r_snap_valid) begin
            r_state <= S_SEND;
            r_idx   <= 5'd0;
            r_csum  <= 8'h00;
          end
        end
        S_SEND: begin
          if (w_rise || resend)
            r_overrun <= 1'b1;
          if (tx.tx_ready) begin
            if (r_idx == c_LAST_IDX)
              r_state <= S_END;
            else
              r_idx <= r_idx + 5'd1;
            // The checksum covers payload bytes only, never sync or itself.
            if ((r_idx != 5'd0) && (r_idx != c_LAST_IDX))
              r_csum <= r_csum ^ w_byte;
          end
        end
        S_END: begin
          if (w_rise || resend)
            r_overrun <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx.tx_valid = w_send;
  assign tx.tx_data  = w_send ? w_byte : 8'h00;
  assign busy        = (r_state != S_IDLE);
  assign frame_done  = (r_state == S_END);
  assign overrun     = r_overrun;

endmodule
`default_nettype wire
